cpu_ctrl_decode: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 64 ++++++
 rtl/cpu_flag_reg.sv | 27 ++
 rtl/cpu_ctrl_decode.sv | 154 +++++++++++++++
 tb/tb_cpu_ctrl_decode.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the LEGv8 main decoder:
//   - 11-bit opcode constants with the prefix mask that each one is matched under
//   - ALU_cntrl encodings
//   - ctrl_t, the packed control word that the decoder fills in
//   - op_match(), the masked-prefix compare that the decoder uses
package cpu_ctrl_pkg;

  // ALU operation codes carried on ALU_cntrl.
  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;

  // Prefix masks. A set bit takes part in the compare.
  localparam logic [10:0] MASK_FULL = 11'b111_1111_1111;  // R/D formats
  localparam logic [10:0] MASK_I10  = 11'b111_1111_1110;  // I format (ADDI)
  localparam logic [10:0] MASK_CB8  = 11'b111_1111_1000;  // CB format
  localparam logic [10:0] MASK_B6   = 11'b111_1110_0000;  // B format

  // Opcode values. Bits outside the mask are zero.
  localparam logic [10:0] OP_ADDI  = 11'b100_1000_1000;
  localparam logic [10:0] OP_ADDS  = 11'b101_0101_1000;
  localparam logic [10:0] OP_SUBS  = 11'b111_0101_1000;
  localparam logic [10:0] OP_LDUR  = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR  = 11'b111_1100_0000;
  localparam logic [10:0] OP_B     = 11'b000_1010_0000;
  localparam logic [10:0] OP_BL    = 11'b100_1010_0000;
  localparam logic [10:0] OP_BR    = 11'b110_1011_0000;
  localparam logic [10:0] OP_CBZ   = 11'b101_1010_0000;
  localparam logic [10:0] OP_BCOND = 11'b010_1010_0000;
  localparam logic [10:0] OP_LSL   = 11'b110_1001_1011;
  localparam logic [10:0] OP_LSR   = 11'b110_1001_1010;

  // Full set of decode outputs, plus the flag-register load enable.
  typedef struct packed {
    logic       uncond_br;
    logic       branch;
    logic       branch_reg;
    logic       branch_link;
    logic       reg2loc;
    logic       alu_src;
    logic       imm;
    logic       alu_sh;
    logic       shift_dirn;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       alu_on;
    logic       set_flags;
    logic [2:0] alu_cntrl;
    logic       flag_we;
  } ctrl_t;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] value,
                                    input logic [10:0] mask);
    return (op & mask) == value;
  endfunction

endpackage

// File: rtl/cpu_flag_reg.sv
// cpu_flag_reg
// 4-bit architectural condition-flag register with load enable and
// synchronous active-high reset. Reset has priority over the load.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset, clears q
//   en   in  load enable
//   d    in  [3:0] next flags {carry, zero, overflow, negative}
//   q    out [3:0] stored flags
module cpu_flag_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] d,
  output logic [3:0] q
);

  // NOTE: state registers use non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create simulation order races.
  always_ff @(posedge clk) begin
    if (rst)
      q <= 4'b0000;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode
// Main instruction decoder and ALU control for the single-cycle LEGv8 CPU,
// plus the condition-flag register consulted by conditional branches.
// Optional feature macro: CPU_CTRL_SHIFT_EN enables LSL/LSR decode; when it
// is undefined those opcodes decode as NOP and ALU_SH/shiftDirn are tied 0.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   opcode[10:0]                      instruction[31:21]
//   carry_out, zero, overflow, negative   live ALU status
//   uncondBr, branch, branchReg, branchLink   PC/link selects
//   Reg2Loc, ALU_Src, Imm, ALU_SH, shiftDirn  datapath mux selects
//   memToReg, memWrite, memRead, RegWrite     memory / writeback enables
//   ALU_on, set_flags                 ALU in use / PC may consult flags
//   ALU_cntrl[2:0]                    ALU operation
//   flags[3:0]                        stored {carry, zero, overflow, negative}
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] opcode,
  input  logic        carry_out,
  input  logic        zero,
  input  logic        overflow,
  input  logic        negative,
  output logic        uncondBr,
  output logic        branch,
  output logic        branchReg,
  output logic        branchLink,
  output logic        Reg2Loc,
  output logic        ALU_Src,
  output logic        Imm,
  output logic        ALU_SH,
  output logic        shiftDirn,
  output logic        memToReg,
  output logic        memWrite,
  output logic        memRead,
  output logic        RegWrite,
  output logic        ALU_on,
  output logic        set_flags,
  output logic [2:0]  ALU_cntrl,
  output logic [3:0]  flags
);

  ctrl_t ctrl;

  // First match wins; the if/else order is most specific prefix first.
  always_comb begin
    // NOTE: default the whole word before the chain so every path assigns
    // every field; a missing default would infer latches.
    ctrl = '0;
    if (rst) begin
      ctrl = '0;  // reset forces all decode outputs low
    end else if (op_match(opcode, OP_ADDS, MASK_FULL)) begin
      ctrl.reg_write = 1'b1;
      ctrl.reg2loc   = 1'b1;
      ctrl.alu_on    = 1'b1;
      ctrl.set_flags = 1'b1;
      ctrl.alu_cntrl = ALU_ADD;
      ctrl.flag_we   = 1'b1;
    end else if (op_match(opcode, OP_SUBS, MASK_FULL)) begin
      ctrl.reg_write = 1'b1;
      ctrl.reg2loc   = 1'b1;
      ctrl.alu_on    = 1'b1;
      ctrl.set_flags = 1'b1;
      ctrl.alu_cntrl = ALU_SUB;
      ctrl.flag_we   = 1'b1;
    end else if (op_match(opcode, OP_LDUR, MASK_FULL)) begin
      ctrl.reg_write  = 1'b1;
      ctrl.alu_src    = 1'b1;
      ctrl.mem_to_reg = 1'b1;
      ctrl.mem_read   = 1'b1;
      ctrl.alu_on     = 1'b1;
      ctrl.alu_cntrl  = ALU_ADD;
    end else if (op_match(opcode, OP_STUR, MASK_FULL)) begin
      // Reg2Loc stays 0 so port B reads Rd, the store data.
      ctrl.alu_src   = 1'b1;
      ctrl.mem_write = 1'b1;
      ctrl.alu_on    = 1'b1;
      ctrl.alu_cntrl = ALU_ADD;
    end else if (op_match(opcode, OP_BR, MASK_FULL)) begin
      ctrl.branch_reg = 1'b1;
`ifdef CPU_CTRL_SHIFT_EN
    end else if (op_match(opcode, OP_LSL, MASK_FULL)) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_sh    = 1'b1;
    end else if (op_match(opcode, OP_LSR, MASK_FULL)) begin
      ctrl.reg_write  = 1'b1;
      ctrl.alu_sh     = 1'b1;
      ctrl.shift_dirn = 1'b1;
`endif
    end else if (op_match(opcode, OP_ADDI, MASK_I10)) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_src   = 1'b1;
      ctrl.imm       = 1'b1;
      ctrl.alu_on    = 1'b1;
      ctrl.alu_cntrl = ALU_ADD;
    end else if (op_match(opcode, OP_CBZ, MASK_CB8)) begin
      // Reg2Loc = 0: the tested register sits in the Rt/Rd field.
      ctrl.branch    = 1'b1;
      ctrl.alu_on    = 1'b1;
      ctrl.set_flags = 1'b1;
      ctrl.alu_cntrl = ALU_PASSB;
    end else if (op_match(opcode, OP_BCOND, MASK_CB8)) begin
      ctrl.branch    = 1'b1;
      ctrl.set_flags = 1'b1;
    end else if (op_match(opcode, OP_B, MASK_B6)) begin
      ctrl.branch    = 1'b1;
      ctrl.uncond_br = 1'b1;
    end else if (op_match(opcode, OP_BL, MASK_B6)) begin
      // The link value passes through the ALU on operand B.
      ctrl.branch      = 1'b1;
      ctrl.uncond_br   = 1'b1;
      ctrl.branch_link = 1'b1;
      ctrl.reg_write   = 1'b1;
      ctrl.alu_on      = 1'b1;
      ctrl.alu_cntrl   = ALU_PASSB;
    end
  end

  assign uncondBr   = ctrl.uncond_br;
  assign branch     = ctrl.branch;
  assign branchReg  = ctrl.branch_reg;
  assign branchLink = ctrl.branch_link;
  assign Reg2Loc    = ctrl.reg2loc;
  assign ALU_Src    = ctrl.alu_src;
  assign Imm        = ctrl.imm;
  assign memToReg   = ctrl.mem_to_reg;
  assign memWrite   = ctrl.mem_write;
  assign memRead    = ctrl.mem_read;
  assign RegWrite   = ctrl.reg_write;
  assign ALU_on     = ctrl.alu_on;
  assign set_flags  = ctrl.set_flags;
  assign ALU_cntrl  = ctrl.alu_cntrl;

`ifdef CPU_CTRL_SHIFT_EN
  assign ALU_SH     = ctrl.alu_sh;
  assign shiftDirn  = ctrl.shift_dirn;
`else
  assign ALU_SH     = 1'b0;
  assign shiftDirn  = 1'b0;
  logic unused_shift;
  assign unused_shift = ctrl.alu_sh ^ ctrl.shift_dirn;
`endif

  cpu_flag_reg u_flag_reg (
    .clk (clk),
    .rst (rst),
    .en  (ctrl.flag_we),
    .d   ({carry_out, zero, overflow, negative}),
    .q   (flags)
  );

endmodule

// File: tb/tb_cpu_ctrl_decode.sv
// tb_cpu_ctrl_decode
// Directed bench for cpu_ctrl_decode. Each step drives opcode/status/rst,
// pushes the expected control word and flag values onto a scoreboard queue,
// then pops and compares: control word and flags before the clock edge,
// flags again after the edge.
module tb_cpu_ctrl_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] opcode;
  logic        carry_out, zero, overflow, negative;
  logic        uncondBr, branch, branchReg, branchLink;
  logic        Reg2Loc, ALU_Src, Imm, ALU_SH, shiftDirn;
  logic        memToReg, memWrite, memRead, RegWrite;
  logic        ALU_on, set_flags;
  logic [2:0]  ALU_cntrl;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  cpu_ctrl_decode dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .carry_out(carry_out), .zero(zero), .overflow(overflow), .negative(negative),
    .uncondBr(uncondBr), .branch(branch), .branchReg(branchReg), .branchLink(branchLink),
    .Reg2Loc(Reg2Loc), .ALU_Src(ALU_Src), .Imm(Imm), .ALU_SH(ALU_SH), .shiftDirn(shiftDirn),
    .memToReg(memToReg), .memWrite(memWrite), .memRead(memRead), .RegWrite(RegWrite),
    .ALU_on(ALU_on), .set_flags(set_flags), .ALU_cntrl(ALU_cntrl), .flags(flags)
  );

  // Observed control word layout (bit positions for expected values).
  localparam logic [17:0] C_UNCOND = 18'h1 << 17;
  localparam logic [17:0] C_BRANCH = 18'h1 << 16;
  localparam logic [17:0] C_BRREG  = 18'h1 << 15;
  localparam logic [17:0] C_LINK   = 18'h1 << 14;
  localparam logic [17:0] C_R2L    = 18'h1 << 13;
  localparam logic [17:0] C_ASRC   = 18'h1 << 12;
  localparam logic [17:0] C_IMM    = 18'h1 << 11;
  localparam logic [17:0] C_ASH    = 18'h1 << 10;
  localparam logic [17:0] C_SDIR   = 18'h1 << 9;
  localparam logic [17:0] C_M2R    = 18'h1 << 8;
  localparam logic [17:0] C_MWR    = 18'h1 << 7;
  localparam logic [17:0] C_MRD    = 18'h1 << 6;
  localparam logic [17:0] C_REGW   = 18'h1 << 5;
  localparam logic [17:0] C_ALUON  = 18'h1 << 4;
  localparam logic [17:0] C_SETF   = 18'h1 << 3;
  localparam logic [17:0] K_PASSB  = 18'd0;
  localparam logic [17:0] K_ADD    = 18'd2;
  localparam logic [17:0] K_SUB    = 18'd3;

  typedef struct {
    string       tag;
    logic [17:0] ctrl;
    logic [3:0]  flags_pre;
    logic [3:0]  flags_post;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model_flags;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [17:0] observed_ctrl();
    return {uncondBr, branch, branchReg, branchLink, Reg2Loc, ALU_Src, Imm,
            ALU_SH, shiftDirn, memToReg, memWrite, memRead, RegWrite,
            ALU_on, set_flags, ALU_cntrl};
  endfunction

  // Drive one step. 'loads' states whether this opcode should update the flags.
  task automatic step(input string tag, input logic r, input logic [10:0] op,
                      input logic [3:0] status, input logic [17:0] exp_ctrl,
                      input logic loads);
    exp_t e, got;
    @(negedge clk);
    rst = r;
    opcode = op;
    {carry_out, zero, overflow, negative} = status;
    e.tag        = tag;
    e.ctrl       = exp_ctrl;
    e.flags_pre  = model_flags;
    e.flags_post = r ? 4'b0000 : (loads ? status : model_flags);
    model_flags  = e.flags_post;
    sb.push_back(e);

    #1;
    got = sb.pop_front();
    checks++;
    assert (observed_ctrl() === got.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl observed=%b expected=%b", got.tag, observed_ctrl(), got.ctrl);
    end
    checks++;
    assert (flags === got.flags_pre) else begin
      errors++;
      $error("FAIL %s flags_pre observed=%b expected=%b", got.tag, flags, got.flags_pre);
    end

    @(posedge clk);
    #1;
    checks++;
    assert (flags === got.flags_post) else begin
      errors++;
      $error("FAIL %s flags_post observed=%b expected=%b", got.tag, flags, got.flags_post);
    end
  endtask

  initial begin
    logic [17:0] exp_lsl, exp_lsr;
`ifdef CPU_CTRL_SHIFT_EN
    exp_lsl = C_REGW | C_ASH;
    exp_lsr = C_REGW | C_ASH | C_SDIR;
`else
    exp_lsl = 18'd0;
    exp_lsr = 18'd0;
`endif
    rst = 1'b1;
    opcode = 11'b10101011000;
    {carry_out, zero, overflow, negative} = 4'b1111;
    model_flags = 4'bxxxx;  // flag register is unknown until the first edge

    // Reset with ADDS asserted: outputs low, flags clear at the edge.
    step("rst_adds", 1'b1, 11'b10101011000, 4'b1111, 18'd0, 1'b1);
    step("addi",     1'b0, 11'b10010001000, 4'b1111,
         C_REGW | C_ASRC | C_IMM | C_ALUON | K_ADD, 1'b0);
    step("subs",     1'b0, 11'b11101011000, 4'b1100,
         C_REGW | C_R2L | C_ALUON | C_SETF | K_SUB, 1'b1);
    step("ldur",     1'b0, 11'b11111000010, 4'b0011,
         C_REGW | C_ASRC | C_M2R | C_MRD | C_ALUON | K_ADD, 1'b0);
    step("stur",     1'b0, 11'b11111000000, 4'b1010,
         C_ASRC | C_MWR | C_ALUON | K_ADD, 1'b0);
    step("bl",       1'b0, 11'b10010100000, 4'b0101,
         C_BRANCH | C_UNCOND | C_LINK | C_REGW | C_ALUON | K_PASSB, 1'b0);
    step("cbz",      1'b0, 11'b10110100000, 4'b0110,
         C_BRANCH | C_ALUON | C_SETF | K_PASSB, 1'b0);
    step("adds",     1'b0, 11'b10101011000, 4'b0011,
         C_REGW | C_R2L | C_ALUON | C_SETF | K_ADD, 1'b1);
    // B.cond right after ADDS sees the new flags (flags_pre check).
    step("bcond",    1'b0, 11'b01010100101, 4'b1111, C_BRANCH | C_SETF, 1'b0);
    step("b",        1'b0, 11'b00010110011, 4'b1000, C_BRANCH | C_UNCOND, 1'b0);
    step("br",       1'b0, 11'b11010110000, 4'b1001, C_BRREG, 1'b0);
    step("lsl",      1'b0, 11'b11010011011, 4'b1110, exp_lsl, 1'b0);
    step("lsr",      1'b0, 11'b11010011010, 4'b0111, exp_lsr, 1'b0);
    step("nop_zero", 1'b0, 11'b00000000000, 4'b1111, 18'd0, 1'b0);
    step("addi_odd", 1'b0, 11'b10010001001, 4'b0000,
         C_REGW | C_ASRC | C_IMM | C_ALUON | K_ADD, 1'b0);
    // One bit past the ADDI prefix: must not match anything.
    step("near_addi", 1'b0, 11'b10010001010, 4'b0000, 18'd0, 1'b0);
    step("near_subs", 1'b0, 11'b11101011001, 4'b1111, 18'd0, 1'b0);
    step("subs2",    1'b0, 11'b11101011000, 4'b0101,
         C_REGW | C_R2L | C_ALUON | C_SETF | K_SUB, 1'b1);
    // Reset together with SUBS: reset wins.
    step("rst_subs", 1'b1, 11'b11101011000, 4'b1111, 18'd0, 1'b1);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard leftover observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
